// File: rtl/router_pkg.sv
// router_pkg: shared types for the per-channel router packet FIFO.
// Holds default widths, the read-side packet FSM states and the stored entry
// layout {hdr, data} at the default byte width.
package router_pkg;

  localparam int DATA_W_DEF  = 8;  // default payload byte width
  localparam int LEN_LSB_DEF = 2;  // header length field is data[DATA_W-1:LEN_LSB]

  typedef enum logic {
    RD_IDLE   = 1'b0,  // waiting for a header byte
    RD_IN_PKT = 1'b1   // inside a packet, counting payload + parity
  } rd_state_t;

  typedef struct packed {
    logic                  hdr;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/router_fifo_mem.sv
// router_fifo_mem: reset-free dual-port storage array for the packet FIFO.
// Ports: clock; write port wr_en/wr_addr/wr_data (synchronous write);
//        read port rd_en/rd_addr -> rd_data (registered, holds when rd_en=0).
module router_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware byte FIFO for one router output channel.
// Ports: clock/reset (async, active-high)/soft_reset; write side write_enb,
//        lfd_state (header tag), data_in; read side read_enb -> data_out,
//        dout_valid, sop, eop (1-cycle latency); status empty/full/
//        almost_full/almost_empty/level; pulses overflow/underflow/pkt_err/timeout.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 16,
  parameter int LEN_LSB   = LEN_LSB_DEF,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int TIMEOUT   = 30
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     lfd_state,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     read_enb,
  output logic [DATA_W-1:0]        data_out,
  output logic                     dout_valid,
  output logic                     sop,
  output logic                     eop,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     pkt_err,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = DATA_W - LEN_LSB + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef struct packed {
    logic              hdr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  rd_state_t     state, state_nxt;
  logic [RW-1:0] remaining, remaining_nxt;
  fifo_entry_t   wr_entry, rd_entry;
  logic          wr_ok, rd_ok, tmo_hit, flush;

  assign empty        = (level == '0);
  assign full         = (level == LW'(DEPTH));
  assign almost_full  = (level >= LW'(AF_THRESH));
  assign almost_empty = (level <= LW'(AE_THRESH));

  // Auto-flush fires on the edge that would complete TIMEOUT idle cycles.
  assign tmo_hit = (TIMEOUT != 0) && !empty && !read_enb && (timer == TW'(TIMEOUT - 1));
  assign flush   = soft_reset | tmo_hit;

  // Gating uses the pre-edge level, so write-at-full is rejected even with a read.
  assign wr_ok = write_enb & ~full & ~flush;
  assign rd_ok = read_enb & ~empty & ~flush;

  assign wr_entry = '{hdr: lfd_state, data: data_in};

  router_fifo_mem #(
    .WIDTH(DATA_W + 1),
    .DEPTH(DEPTH)
  ) u_mem (
    .clock  (clock),
    .wr_en  (wr_ok),
    .wr_addr(wr_ptr),
    .wr_data(wr_entry),
    .rd_en  (rd_ok),
    .rd_addr(rd_ptr),
    .rd_data(rd_entry)
  );

  assign data_out = dout_valid ? rd_entry.data : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      timer  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      timer  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(wr_ok) - LW'(rd_ok);
      timer <= (!empty && !read_enb) ? timer + 1'b1 : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      dout_valid <= rd_ok;
      overflow   <= write_enb & full & ~flush;
      underflow  <= read_enb & empty & ~flush;
      timeout    <= tmo_hit & ~soft_reset;
    end
  end

  // The packet FSM judges the byte currently on data_out against the state
  // left by earlier bytes, so sop/eop/pkt_err line up with the delivered byte
  // while the registered memory read keeps the header bit off the
  // critical path. The state absorbs that byte on the following edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RD_IDLE;
      remaining <= '0;
    end else if (flush) begin
      state     <= RD_IDLE;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    sop           = 1'b0;
    eop           = 1'b0;
    pkt_err       = 1'b0;
    if (dout_valid) begin
      if (rd_entry.hdr) begin
        // A header inside a packet truncates it and starts a new one.
        sop           = 1'b1;
        pkt_err       = (state == RD_IN_PKT);
        state_nxt     = RD_IN_PKT;
        remaining_nxt = RW'(rd_entry.data[DATA_W-1:LEN_LSB]) + 1'b1;
      end else if (state == RD_IN_PKT) begin
        remaining_nxt = remaining - 1'b1;
        if (remaining == RW'(1)) begin
          eop       = 1'b1;
          state_nxt = RD_IDLE;
        end
      end else begin
        pkt_err = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
module tb_router_pkt_fifo;
  import router_pkg::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 30;
  localparam int DW    = DATA_W_DEF;
  localparam int LL    = LEN_LSB_DEF;

  logic clock = 1'b0;
  logic reset, soft_reset, write_enb, lfd_state, read_enb;
  logic [DW-1:0] data_in, data_out;
  logic dout_valid, sop, eop, empty, full, almost_full, almost_empty;
  logic overflow, underflow, pkt_err, timeout;
  logic [$clog2(DEPTH):0] level;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte queue plus packet bookkeeping.
  entry_t q[$];
  int tmr;
  bit in_pkt;
  int left;
  bit e_dv, e_sop, e_eop, e_err, e_ovf, e_udf, e_tmo;
  logic [DW-1:0] e_dat;
  int tmo_seen;

  always #5 clock = ~clock;

  router_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .LEN_LSB(LL),
                    .AF_THRESH(DEPTH-2), .AE_THRESH(2), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .dout_valid(dout_valid),
    .sop(sop), .eop(eop), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow), .pkt_err(pkt_err),
    .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int lv = q.size();
    check({ph, ".data_out"},   32'(data_out),     32'(e_dat));
    check({ph, ".dout_valid"}, 32'(dout_valid),   32'(e_dv));
    check({ph, ".sop"},        32'(sop),          32'(e_sop));
    check({ph, ".eop"},        32'(eop),          32'(e_eop));
    check({ph, ".pkt_err"},    32'(pkt_err),      32'(e_err));
    check({ph, ".overflow"},   32'(overflow),     32'(e_ovf));
    check({ph, ".underflow"},  32'(underflow),    32'(e_udf));
    check({ph, ".timeout"},    32'(timeout),      32'(e_tmo));
    check({ph, ".level"},      32'(level),        32'(lv));
    check({ph, ".empty"},      32'(empty),        32'(lv == 0));
    check({ph, ".full"},       32'(full),         32'(lv == DEPTH));
    check({ph, ".afull"},      32'(almost_full),  32'(lv >= DEPTH - 2));
    check({ph, ".aempty"},     32'(almost_empty), 32'(lv <= 2));
  endtask

  task automatic model_clear();
    q.delete();
    tmr = 0; in_pkt = 0; left = 0;
    {e_dv, e_sop, e_eop, e_err, e_ovf, e_udf, e_tmo} = '0;
    e_dat = '0;
  endtask

  // One clock cycle: drive on the falling edge, predict, check 1ns after the rise.
  task automatic step(input bit we, input bit hdr, input logic [DW-1:0] din,
                      input bit re, input bit sr, input string ph);
    entry_t e;
    bit was_empty, was_full, tmo;
    @(negedge clock);
    write_enb = we; lfd_state = hdr; data_in = din; read_enb = re; soft_reset = sr;
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    tmo = !was_empty && !re && (tmr == TMO - 1);
    {e_dv, e_sop, e_eop, e_err, e_ovf, e_udf, e_tmo} = '0;
    e_dat = '0;
    if (sr || tmo) begin
      model_clear();
      e_tmo = tmo && !sr;
    end else begin
      e_ovf = we && was_full;
      e_udf = re && was_empty;
      tmr = (!was_empty && !re) ? tmr + 1 : 0;
      if (re && !was_empty) begin
        e = q.pop_front();
        e_dv = 1; e_dat = e.data;
        if (e.hdr) begin
          e_sop = 1; e_err = in_pkt;
          in_pkt = 1; left = int'(e.data[DW-1:LL]) + 1;  // payload + parity
        end else if (in_pkt) begin
          left--;
          if (left == 0) begin e_eop = 1; in_pkt = 0; end
        end else begin
          e_err = 1;
        end
      end
      if (we && !was_full) q.push_back('{hdr: hdr, data: din});
    end
    @(posedge clock); #1;
    if (timeout) tmo_seen++;
    check_all(ph);
  endtask

  task automatic wr(input bit hdr, input logic [DW-1:0] din, input string ph);
    step(1, hdr, din, 0, 0, ph);
  endtask

  task automatic rd(input string ph);
    step(0, 0, '0, 1, 0, ph);
  endtask

  task automatic idle(input string ph);
    step(0, 0, '0, 0, 0, ph);
  endtask

  task automatic drain(input string ph);
    for (int i = 0; i < DEPTH + 1; i++) if (q.size() != 0) rd(ph);
  endtask

  // Assert reset between edges and check outputs before any clock edge.
  task automatic async_reset(input string ph);
    @(negedge clock);
    #2;
    reset = 1; write_enb = 0; read_enb = 0; soft_reset = 0; lfd_state = 0; data_in = '0;
    #1;
    model_clear();
    check_all(ph);
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    reset = 1; soft_reset = 0; write_enb = 0; lfd_state = 0; data_in = '0; read_enb = 0;
    model_clear();
    tmo_seen = 0;
    #12;
    check_all("reset");
    @(negedge clock);
    reset = 0;

    // Basic packet: header len 3, 3 payload, parity, then 5 reads.
    wr(1, 8'h0C, "pkt.w"); wr(0, 8'hA1, "pkt.w"); wr(0, 8'hA2, "pkt.w");
    wr(0, 8'hA3, "pkt.w"); wr(0, 8'h5F, "pkt.w");
    check("pkt_level5", 32'(level), 32'd5);
    rd("pkt.r");
    check("pkt_sop", 32'(sop), 32'd1);
    rd("pkt.r"); rd("pkt.r"); rd("pkt.r"); rd("pkt.r");
    check("pkt_eop", 32'(eop), 32'd1);
    check("pkt_empty", 32'(empty), 32'd1);

    // Fill to full, overflow, then read+write at full.
    for (int i = 0; i < DEPTH; i++) wr(0, DW'(i), "fill");
    check("fill_full", 32'(full), 32'd1);
    wr(0, 8'hEE, "ovf");
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd16);
    step(1, 0, 8'hDD, 1, 0, "full_rw");
    check("full_rw_level", 32'(level), 32'd15);
    drain("drain1");

    // Underflow and read+write at level 1.
    rd("udf");
    check("udf_pulse", 32'(underflow), 32'd1);
    wr(1, 8'h00, "lvl1");
    step(1, 0, 8'h33, 1, 0, "lvl1_rw");
    check("lvl1_level", 32'(level), 32'd1);
    drain("drain2");

    // Truncated packet, then a stray payload byte read in idle.
    wr(1, 8'h08, "trunc.w"); wr(0, 8'h11, "trunc.w"); wr(1, 8'h04, "trunc.w");
    wr(0, 8'h22, "trunc.w"); wr(0, 8'h23, "trunc.w"); wr(0, 8'h77, "trunc.w");
    rd("trunc.r"); rd("trunc.r"); rd("trunc.r");
    check("trunc_err", 32'(pkt_err), 32'd1);
    check("trunc_sop", 32'(sop), 32'd1);
    rd("trunc.r"); rd("trunc.r");
    check("trunc_eop", 32'(eop), 32'd1);
    rd("stray.r");
    check("stray_err", 32'(pkt_err), 32'd1);

    // Timeout fires within 30 idle cycles after writing 3 bytes.
    tmo_seen = 0;
    wr(1, 8'h04, "tmo.w"); wr(0, 8'h01, "tmo.w"); wr(0, 8'h02, "tmo.w");
    for (int i = 0; i < TMO; i++) idle("tmo.idle");
    check("tmo_count", 32'(tmo_seen), 32'd1);
    check("tmo_empty", 32'(empty), 32'd1);

    // A read just before expiry restarts the timer.
    tmo_seen = 0;
    wr(1, 8'h04, "tmo2.w"); wr(0, 8'h01, "tmo2.w"); wr(0, 8'h02, "tmo2.w");
    for (int i = 0; i < 26; i++) idle("tmo2.idle");
    rd("tmo2.r");
    for (int i = 0; i < 10; i++) idle("tmo2.idle");
    check("tmo2_none", 32'(tmo_seen), 32'd0);
    check("tmo2_level", 32'(level), 32'd2);
    drain("drain3");

    // Soft reset during read+write at level 8.
    for (int i = 0; i < 8; i++) wr(0, DW'(8'h40 + i), "sr.w");
    step(1, 0, 8'h99, 1, 1, "sr");
    check("sr_level", 32'(level), 32'd0);
    check("sr_dv", 32'(dout_valid), 32'd0);
    wr(1, 8'h00, "sr.new");
    check("sr_new_level", 32'(level), 32'd1);
    wr(0, 8'h5A, "sr.new");
    rd("sr.new.r"); rd("sr.new.r");
    check("sr_new_eop", 32'(eop), 32'd1);

    // Async reset mid-packet; afterwards a payload byte read flags pkt_err.
    wr(1, 8'h0C, "ar.w"); wr(0, 8'h01, "ar.w"); wr(0, 8'h02, "ar.w");
    rd("ar.r"); rd("ar.r");
    async_reset("ar");
    wr(0, 8'h03, "ar.post"); rd("ar.post");
    check("ar_err", 32'(pkt_err), 32'd1);

    // Randomized traffic: balanced, then read-starved to hit full/timeout.
    for (int i = 0; i < 2000; i++) begin
      bit we = ($urandom_range(0, 99) < 55);
      bit re = ($urandom_range(0, 99) < 45);
      bit hd = ($urandom_range(0, 99) < 15);
      bit sr = ($urandom_range(0, 299) == 0);
      step(we, hd, DW'($urandom), re, sr, "rand");
    end
    for (int i = 0; i < 800; i++) begin
      bit we = ($urandom_range(0, 99) < 30);
      bit re = ($urandom_range(0, 99) < 4);
      bit hd = ($urandom_range(0, 99) < 20);
      step(we, hd, DW'($urandom), re, 0, "slow");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
- Parametrised, packet-aware FIFO for one router output channel; next generation of the per-channel router FIFO.
- Stores bytes tagged with a header flag and tracks packet boundaries on the read side, marking SOP/EOP.
- Adds programmable almost-full/almost-empty flags, an occupancy level, overflow/underflow/framing error pulses, and a built-in read-timeout flush.
- Sits between the router FSM/write side and the destination read port.

Parameters:
DATA_W, 8, payload byte width (>=4)
DEPTH, 16, entries; power of two, >=4
LEN_LSB, 2, LSB of the length field in the header byte; length = data[DATA_W-1:LEN_LSB]
AF_THRESH, DEPTH-2, almost_full asserted when level >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH
TIMEOUT, 30, consecutive unread cycles before auto-flush; 0 disables

Ports:
clock  in  1  single clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
soft_reset  in  1  synchronous flush request
write_enb  in  1  write request
lfd_state  in  1  marks data_in as a header byte
data_in  in  DATA_W  write byte
read_enb  in  1  read request
data_out  out  DATA_W  registered read byte; 0 when dout_valid=0
dout_valid  out  1  data_out valid this cycle
sop  out  1  data_out is a header
eop  out  1  data_out is the last (parity) byte of a packet
empty  out  1  level==0
full  out  1  level==DEPTH
almost_full  out  1  see AF_THRESH
almost_empty  out  1  see AE_THRESH
level  out  $clog2(DEPTH)+1  occupancy
overflow  out  1  1-cycle pulse: write rejected
underflow  out  1  1-cycle pulse: read rejected
pkt_err  out  1  1-cycle pulse: framing error
timeout  out  1  1-cycle pulse: auto-flush fired

Behaviour:
- Reset (async, active-high): pointers, level, read state and timer cleared. Outputs: empty=1, almost_empty=1, all other outputs 0. Memory contents are not cleared.
- Storage: DEPTH x (DATA_W+1) entries = {lfd_state, data_in}. Pointers wrap modulo DEPTH.
- Write: accepted when write_enb && !full. Entry stored, wr_ptr+1. If write_enb && full: no state change, overflow=1 next cycle.
- Read: accepted when read_enb && !empty. Registered read: data_out/dout_valid/sop/eop update on the same edge that advances rd_ptr (1-cycle latency from read_enb). If read_enb && empty: underflow=1, dout_valid=0.
- Simultaneous read and write: both are accepted if individually legal, and level is unchanged. Full/empty gating uses the level before the edge, so a write while full is rejected even if a read also occurs.
- Flags are combinational from level. level width is $clog2(DEPTH)+1 so DEPTH is representable.
- Read-side FSM, states IDLE and IN_PKT; remaining counter is DATA_W-LEN_LSB+1 bits:
  - IDLE, header read: sop=1, remaining=len+1 (payload + parity), go to IN_PKT.
  - IDLE, non-header read: byte delivered, sop=eop=0, pkt_err=1.
  - IN_PKT, non-header read: remaining-1. When remaining was 1, eop=1 and go to IDLE.
  - IN_PKT, header read (truncated packet): pkt_err=1, treated as a new header (sop=1, reload remaining).
  - Length 0: header followed by parity only; the parity byte gets eop.
- Timeout: counter increments each cycle with !empty && !read_enb, and clears otherwise. When it reaches TIMEOUT, an internal flush occurs and timeout=1 for one cycle.
- Flush (soft_reset=1 or timeout): pointers, level, FSM, remaining and timer cleared on that edge. dout_valid/sop/eop/err pulses go to 0. Any write or read in the same cycle is discarded. soft_reset has priority over all other activity.
- reset asserted mid-packet: state is cleared immediately. After release, the first read of a non-header byte flags pkt_err.
- No tri-state outputs.

Decomposition:
- Package router_pkg: DATA_W default, LEN_LSB, the FSM state enum (RD_IDLE, RD_IN_PKT), and the entry struct {hdr, data}.
- One sub-module, router_fifo_mem: dual-port array with synchronous write and registered read, reset-free.
- Pointer, level, FSM and timeout logic live in the top module.

Test Plan:
- Reset, then header 0x0C (len 3), 3 payload bytes, 1 parity byte, then 5 reads -> level 5→0. Header has sop=1, the 5th byte has eop=1, and empty=1 after the last read.
- Write 16 bytes with no reads -> full=1, almost_full=1 from level 14. 17th write gives overflow pulse and level stays 16. Simultaneous read+write at level 16 -> write rejected, level 15.
- Read while empty -> underflow pulse, dout_valid=0, level 0. Write+read together at level 1 -> level stays 1.
- Header len 2, 1 payload, then a new header -> pkt_err pulse on the second header, sop=1, remaining reloaded. A non-header byte read in IDLE -> pkt_err.
- Write 3 bytes and hold read_enb=0 for 30 cycles -> timeout pulse on cycle 30, level 0, empty=1. A read at cycle 29 resets the timer and no timeout fires.
- Assert soft_reset during a simultaneous write/read at level 8 -> level 0, no data delivered, FIFO accepts a new packet on the next cycle. Async reset mid-packet -> outputs return to reset values without waiting for a clock edge.
